// File: rtl/data_memory_ctrl.sv
// Single-port 1024x32 data memory behind a valid/ready request interface.
// Each request takes WAIT_STATES+1 cycles to reach the array, then one response cycle.
module data_memory_ctrl #(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  ram_address,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] wr_data,
   input  logic [3:0]  byte_en,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rd_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_wait_cnt;
   logic [3:0]  w_next_cnt;
   logic        w_accept;
   logic        w_access;
   logic [9:0]  r_addr;
   logic        r_write;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [31:0] r_rd_data;
   logic [31:0] r_mem [1024];

   assign req_ready = (r_state == IDLE) && reset;
   assign rsp_valid = (r_state == RESP);
   assign busy      = (r_state != IDLE);
   assign rd_data   = r_rd_data;

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_wait_cnt;
      w_accept     = 1'b0;
      w_access     = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid && req_ready) begin
               w_accept     = 1'b1;
               w_next_cnt   = 4'(WAIT_STATES);
               w_next_state = WAIT;
            end
         end
         WAIT: begin
            if (r_wait_cnt != 4'd0) begin
               w_next_cnt = r_wait_cnt - 4'd1;
            end else begin
               w_access     = 1'b1;
               w_next_state = RESP;
            end
         end
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_wait_cnt <= 4'd0;
         r_rd_data  <= 32'h0000_0000;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_next_cnt;
         if (w_access && !r_write) begin
            r_rd_data <= r_mem[r_addr];
         end
      end
   end

   // Request fields are captured once at acceptance so later input changes cannot disturb it
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr  <= ram_address;
         r_write <= req_write;
         r_wdata <= wr_data;
         r_be    <= byte_en;
      end
   end

   // Array is never reset; w_access is already blocked while reset holds the FSM in IDLE
   always_ff @(posedge clk) begin
      if (w_access && r_write) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
               r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule
